// File: rtl/ring_link_arbiter.sv
// Two-source ring link arbiter: through-traffic wins by default, with a
// starvation counter that forces a local grant after MaxBurst pass wins.
// Ports: pass_* / local_* are the two valid/ready sources, ring_* is the
// registered one-entry output stage, and *_cnt_o are the stats counters.
// Optional feature macro: RING_ARB_STATS_EN enables the stats counters.
// When it is undefined, both stats ports are tied to 0.
module ring_link_arbiter #(
   parameter type data_t = logic,
   parameter int unsigned MaxBurst = 4
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  data_t       pass_i,
   input  logic        pass_valid_i,
   output logic        pass_ready_o,
   input  data_t       local_i,
   input  logic        local_valid_i,
   output logic        local_ready_o,
   output data_t       ring_o,
   output logic        ring_valid_o,
   input  logic        ring_ready_i,
   output logic [31:0] local_stall_cnt_o,
   output logic [31:0] forced_grant_cnt_o
);

   typedef enum logic {
      PASS_PRIO  = 1'b0,
      LOCAL_PRIO = 1'b1
   } state_e;

   localparam logic [7:0] BurstLim = 8'(MaxBurst);

   state_e     state;
   logic [7:0] starve_cnt;
   logic [7:0] starve_inc;
   logic       can_load;
   logic       pass_gnt;
   logic       local_gnt;

   always_comb begin
      can_load   = !ring_valid_o || ring_ready_i;
      starve_inc = starve_cnt + 8'd1;
      pass_gnt   = 1'b0;
      local_gnt  = 1'b0;
      // Readies are held low during reset so nothing is accepted then.
      if (rst_ni && can_load) begin
         case (state)
            PASS_PRIO: begin
               pass_gnt  = pass_valid_i;
               local_gnt = local_valid_i && !pass_valid_i;
            end
            LOCAL_PRIO: begin
               local_gnt = local_valid_i;
               pass_gnt  = pass_valid_i && !local_valid_i;
            end
            default: begin
               pass_gnt  = 1'b0;
               local_gnt = 1'b0;
            end
         endcase
      end
   end

   assign pass_ready_o  = pass_gnt;
   assign local_ready_o = local_gnt;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state        <= PASS_PRIO;
         starve_cnt   <= 8'd0;
         ring_o       <= '0;
         ring_valid_o <= 1'b0;
      end else if (can_load) begin
         // Stage is empty or draining this cycle, so it can take a new beat.
         ring_valid_o <= pass_gnt || local_gnt;
         if (pass_gnt) begin
            ring_o <= pass_i;
         end else if (local_gnt) begin
            ring_o <= local_i;
         end
         case (state)
            PASS_PRIO: begin
               if (pass_valid_i && local_valid_i) begin
                  if (starve_inc == BurstLim) begin
                     state      <= LOCAL_PRIO;
                     starve_cnt <= 8'd0;
                  end else begin
                     starve_cnt <= starve_inc;
                  end
               end else begin
                  starve_cnt <= 8'd0;
               end
            end
            LOCAL_PRIO: begin
               state <= PASS_PRIO;
            end
            default: begin
               state      <= PASS_PRIO;
               starve_cnt <= 8'd0;
            end
         endcase
      end
   end

`ifdef RING_ARB_STATS_EN
   logic [31:0] stall_q;
   logic [31:0] forced_q;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         stall_q  <= 32'd0;
         forced_q <= 32'd0;
      end else begin
         if (local_valid_i && !local_ready_o && stall_q != '1) begin
            stall_q <= stall_q + 32'd1;
         end
         // Every local grant made in LOCAL_PRIO was forced by starvation.
         if (local_gnt && state == LOCAL_PRIO && forced_q != '1) begin
            forced_q <= forced_q + 32'd1;
         end
      end
   end

   assign local_stall_cnt_o  = stall_q;
   assign forced_grant_cnt_o = forced_q;
`else
   assign local_stall_cnt_o  = 32'd0;
   assign forced_grant_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_ring_link_arbiter.sv
// Directed bench for ring_link_arbiter: MaxBurst=4 and MaxBurst=1 instances.
// Inputs are driven 1 ns after the rising edge and outputs are sampled there.
module tb_ring_link_arbiter;

   logic        clk;
   logic        rst_n;

   logic [7:0]  pass_d, local_d, ring_d;
   logic        pass_v, pass_r, local_v, local_r, ring_v, ring_r;
   logic [31:0] stall_cnt, forced_cnt;

   logic [7:0]  b_pass_d, b_local_d, b_ring_d;
   logic        b_pass_v, b_pass_r, b_local_v, b_local_r, b_ring_v, b_ring_r;
   logic [31:0] b_stall_cnt, b_forced_cnt;

   int checks = 0;
   int errors = 0;

   ring_link_arbiter #(.data_t(logic [7:0]), .MaxBurst(4)) dut (
      .clk_i              (clk),
      .rst_ni             (rst_n),
      .pass_i             (pass_d),
      .pass_valid_i       (pass_v),
      .pass_ready_o       (pass_r),
      .local_i            (local_d),
      .local_valid_i      (local_v),
      .local_ready_o      (local_r),
      .ring_o             (ring_d),
      .ring_valid_o       (ring_v),
      .ring_ready_i       (ring_r),
      .local_stall_cnt_o  (stall_cnt),
      .forced_grant_cnt_o (forced_cnt)
   );

   ring_link_arbiter #(.data_t(logic [7:0]), .MaxBurst(1)) dut_b (
      .clk_i              (clk),
      .rst_ni             (rst_n),
      .pass_i             (b_pass_d),
      .pass_valid_i       (b_pass_v),
      .pass_ready_o       (b_pass_r),
      .local_i            (b_local_d),
      .local_valid_i      (b_local_v),
      .local_ready_o      (b_local_r),
      .ring_o             (b_ring_d),
      .ring_valid_o       (b_ring_v),
      .ring_ready_i       (b_ring_r),
      .local_stall_cnt_o  (b_stall_cnt),
      .forced_grant_cnt_o (b_forced_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_stats(input string tag, input logic [31:0] stall,
                            input logic [31:0] forced);
`ifdef RING_ARB_STATS_EN
      chk({tag, "_stall"}, stall_cnt, stall);
      chk({tag, "_forced"}, forced_cnt, forced);
`else
      chk({tag, "_stall"}, stall_cnt, 32'd0);
      chk({tag, "_forced"}, forced_cnt, 32'd0);
      if (stall == 32'd0 && forced == 32'd0) checks += 0;
`endif
   endtask

   initial begin
      logic [7:0] exp_a [6];
      logic [7:0] exp_b [6];
      int p, l;
      logic lv, pr, lr;

      exp_a = '{8'h50, 8'h51, 8'h52, 8'h53, 8'hC0, 8'h54};
      exp_b = '{8'h50, 8'hC0, 8'h51, 8'hC1, 8'h52, 8'hC2};

      // Reset with both sources asserting valid.
      rst_n   = 1'b0;
      pass_d  = 8'h99; pass_v  = 1'b1;
      local_d = 8'h98; local_v = 1'b1;
      ring_r  = 1'b1;
      b_pass_d = 8'h00; b_pass_v = 1'b0;
      b_local_d = 8'h00; b_local_v = 1'b0;
      b_ring_r = 1'b1;
      tick;
      chk("rst_pass_ready", 32'(pass_r), 32'd0);
      chk("rst_local_ready", 32'(local_r), 32'd0);
      chk("rst_ring_valid", 32'(ring_v), 32'd0);
      chk("rst_ring_data", 32'(ring_d), 32'd0);
      chk("rst_state", 32'(dut.state), 32'd0);
      chk("rst_starve", 32'(dut.starve_cnt), 32'd0);
      chk_stats("rst", 32'd0, 32'd0);

      // Single local beat.
      rst_n   = 1'b1;
      pass_v  = 1'b0;
      local_d = 8'hA5;
      local_v = 1'b1;
      #1;
      chk("single_local_ready", 32'(local_r), 32'd1);
      tick;
      local_v = 1'b0;
      chk("single_valid_c1", 32'(ring_v), 32'd1);
      chk("single_data_c1", 32'(ring_d), 32'hA5);
      tick;
      chk("single_valid_c2", 32'(ring_v), 32'd0);

      // Starvation bound, MaxBurst=4.
      p  = 0;
      lv = 1'b1;
      for (int c = 0; c < 6; c++) begin
         pass_d  = 8'(8'h50 + p);
         pass_v  = 1'b1;
         local_d = 8'hC0;
         local_v = lv;
         #1;
         pr = pass_r;
         lr = local_r;
         chk($sformatf("starve_excl_%0d", c), 32'(pr & lr), 32'd0);
         tick;
         chk($sformatf("starve_out_%0d", c), 32'(ring_d), 32'(exp_a[c]));
         chk($sformatf("starve_vld_%0d", c), 32'(ring_v), 32'd1);
         if (pr) p++;
         if (lr) lv = 1'b0;
      end
      chk_stats("starve", 32'd4, 32'd1);
      pass_v  = 1'b0;
      local_v = 1'b0;
      tick;
      chk("starve_drain", 32'(ring_v), 32'd0);

      // Backpressure with both sources valid.
      pass_d  = 8'h11; pass_v  = 1'b1;
      local_d = 8'h33; local_v = 1'b1;
      tick;
      chk("bp_load", 32'(ring_d), 32'h11);
      ring_r = 1'b0;
      pass_d = 8'h12;
      for (int c = 0; c < 5; c++) begin
         #1;
         chk($sformatf("bp_pass_ready_%0d", c), 32'(pass_r), 32'd0);
         chk($sformatf("bp_local_ready_%0d", c), 32'(local_r), 32'd0);
         tick;
         chk($sformatf("bp_data_%0d", c), 32'(ring_d), 32'h11);
         chk($sformatf("bp_valid_%0d", c), 32'(ring_v), 32'd1);
         chk($sformatf("bp_starve_%0d", c), 32'(dut.starve_cnt), 32'd1);
      end
      ring_r = 1'b1;
      #1;
      chk("bp_release_pass_ready", 32'(pass_r), 32'd1);
      chk("bp_release_local_ready", 32'(local_r), 32'd0);
      tick;
      chk("bp_nobubble_data", 32'(ring_d), 32'h12);
      chk("bp_nobubble_valid", 32'(ring_v), 32'd1);
      chk("bp_starve_after", 32'(dut.starve_cnt), 32'd2);
      pass_d = 8'h13;
      tick;
      pass_d = 8'h14;
      tick;
      chk("yield_in_local_prio", 32'(dut.state), 32'd1);

      // Yield to pass in LOCAL_PRIO with local dropped.
      local_v = 1'b0;
      pass_d  = 8'h22;
      #1;
      chk("yield_pass_ready", 32'(pass_r), 32'd1);
      tick;
      chk("yield_data", 32'(ring_d), 32'h22);
      chk("yield_state", 32'(dut.state), 32'd0);

      // Reset while full and both sources valid.
      pass_d  = 8'h44; pass_v  = 1'b1;
      local_d = 8'h55; local_v = 1'b1;
      rst_n   = 1'b0;
      #1;
      chk("mrst_pass_ready", 32'(pass_r), 32'd0);
      chk("mrst_local_ready", 32'(local_r), 32'd0);
      tick;
      chk("mrst_valid", 32'(ring_v), 32'd0);
      chk("mrst_state", 32'(dut.state), 32'd0);
      chk("mrst_starve", 32'(dut.starve_cnt), 32'd0);
      chk_stats("mrst", 32'd0, 32'd0);
      rst_n   = 1'b1;
      pass_v  = 1'b0;
      local_v = 1'b0;
      tick;
      chk("mrst_idle", 32'(ring_v), 32'd0);

      // MaxBurst=1 alternation.
      p = 0;
      l = 0;
      for (int c = 0; c < 6; c++) begin
         b_pass_d  = 8'(8'h50 + p);
         b_pass_v  = 1'b1;
         b_local_d = 8'(8'hC0 + l);
         b_local_v = 1'b1;
         #1;
         pr = b_pass_r;
         lr = b_local_r;
         tick;
         chk($sformatf("alt_out_%0d", c), 32'(b_ring_d), 32'(exp_b[c]));
         chk($sformatf("alt_vld_%0d", c), 32'(b_ring_v), 32'd1);
         if (pr) p++;
         if (lr) l++;
      end
      b_pass_v  = 1'b0;
      b_local_v = 1'b0;
      tick;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
